mux8_rr_arbiter: RTL and testbench
==================================

# mux8_rr_arbiter

Round-robin arbiter and sequencer for the 8-input, 16-bit select mux. Up to eight requesters present `DW`-bit data with a per-beat `last` marker. The block grants one requester at a time and holds that grant for a whole burst. It drives the 3-bit mux select and presents the selected data to a single downstream consumer over a valid/ready handshake.

## Interface
- `DW`, 16: data width per requester.
- `MAX_HOLD`, 16: maximum BUSY cycles per grant. Used only when `MUX8_ARB_TIMEOUT_EN` is defined. Legal range 2..255.

- `clk`  in  1: the single clock; all state updates on its rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `req`  in  8: per-requester data-valid; bit i belongs to requester i.
- `last`  in  8: per-requester end-of-burst marker; sampled only with the matching `req` bit.
- `in_data`  in  8*DW: requester i data at `[i*DW +: DW]`.
- `ack`  out  8: one-hot, single-cycle; bit i high when requester i's beat is accepted.
- `grant`  out  8: one-hot registered owner; all zero when idle.
- `sel`  out  3: registered mux select; equals the index of the `grant` bit.
- `out_valid`  out  1: downstream data valid.
- `out_data`  out  DW: selected requester's data.
- `out_ready`  in  1: downstream accept.
- `preempt`  out  1: single-cycle pulse when a grant is force-released by timeout.

## Operation
- States are IDLE and BUSY, plus a 3-bit round-robin pointer `ptr` holding the index of the last winner.
- In IDLE, if `req != 0`:
  - The winner is the first set `req` bit searching `ptr+1, ptr+2, …`, wrapping modulo 8.
  - Next cycle: `grant` = one-hot(winner), `sel` = winner, `ptr` = winner, state = BUSY, hold counter = 0.
- In IDLE, if `req == 0`, all state is unchanged.
- In BUSY, the datapath is combinational:
  - `out_valid = req[sel]`.
  - `out_data = in_data[sel*DW +: DW]`.
  - `ack = grant` when `out_valid & out_ready`, else 0.
- A beat transfers on any cycle where `out_valid & out_ready`.
- A transfer with `last[sel]=1` releases the grant: next cycle state = IDLE, `grant` = 0.
- If the owner deasserts `req` mid-burst, the grant is held and `out_valid` = 0; no other requester is served.
- Other requesters' `req`/`last` are ignored while BUSY. They are never acked and never lost; they keep asserting until served.
- In IDLE: `out_valid` = 0, `ack` = 0, `out_data` = `in_data[sel*DW +: DW]` (don't care).
- Fairness: after releasing requester k, requester k has the lowest priority in the next arbitration.

## Timing
- Reset values: state IDLE, `grant`=0, `sel`=0, `ptr`=7 (requester 0 wins first), hold counter 0, `ack`=0, `out_valid`=0, `preempt`=0.
- Grant latency: `req` seen in IDLE at cycle N → `grant`/`sel` valid at N+1. The first beat can transfer at N+1.
- Release bubble: the last beat at cycle M → IDLE at M+1 → the next grant at M+2. Back-to-back bursts therefore cost one idle cycle.
- Throughput within a burst: one beat per cycle while `req[sel] & out_ready`.
- Reset asserted mid-burst: the next cycle returns all reset values. The in-flight burst is abandoned with no further `ack`.
- A single-beat burst (`last`=1 on the first beat) occupies exactly one BUSY cycle.

## Configuration
- `MUX8_ARB_TIMEOUT_EN` defined:
  - An 8-bit hold counter increments on every BUSY cycle and clears on entering BUSY.
  - If the counter equals `MAX_HOLD-1` at the end of a BUSY cycle without a `last` transfer, the grant is released. The next cycle is IDLE, and `preempt` pulses high for that one cycle.
  - A normal beat transfer in that final cycle still completes and is acked.
  - `ptr` keeps the preempted index, so that requester gets the lowest priority next.
- `MUX8_ARB_TIMEOUT_EN` undefined: there is no counter. The grant is released only by a `last` transfer, and `preempt` is tied to 0.

## Test plan
- Reset, then `req`=8'h01, `last`=8'h01, `out_ready`=1, `in_data[15:0]`=16'hA5A5. Expect:
  - `grant`=8'h01 and `sel`=0 one cycle later.
  - `out_data`=16'hA5A5, `ack`=8'h01 for one cycle.
  - IDLE the following cycle.
- `req`=8'hFF held, every beat `last`. Expect the grant order 0,1,2,…,7,0, with one idle cycle between each grant.
- Requester 3 sends a 4-beat burst (`last` on beat 4) while `req[5]` is high. Expect:
  - `ack[3]` four times and `ack[5]` never during the burst.
  - `grant`=8'h20 two cycles after the fourth beat.
- During a granted burst, drop `out_ready` for 3 cycles. Expect `out_valid`=1, `ack`=0, and `grant`/`out_data` stable; transfer resumes when `out_ready`=1.
- With `MUX8_ARB_TIMEOUT_EN`, `MAX_HOLD`=4: requester 2 holds `req` with `last`=0 while `req[6]` is high. Expect:
  - 4 BUSY cycles, then `preempt`=1 for one cycle in IDLE.
  - Next `grant`=8'h40.
  - Without the macro, the grant stays 8'h04 indefinitely.
- Assert `rst` during the second beat of a burst. Expect on the next cycle: `grant`=0, `sel`=0, `out_valid`=0. After release, requester 0 wins first when `req`=8'h81.

Source files
------------

// File: rtl/mux8_rr_arbiter.sv
// Round-robin burst arbiter driving the select of an 8-input mux.
// Define MUX8_ARB_TIMEOUT_EN to force-release grants after MAX_HOLD BUSY cycles.
module mux8_rr_arbiter #(
    parameter int DW       = 16,
    parameter int MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      req,
    input  logic [7:0]      last,
    input  logic [8*DW-1:0] in_data,
    output logic [7:0]      ack,
    output logic [7:0]      grant,
    output logic [2:0]      sel,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    input  logic            out_ready,
    output logic            preempt
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t     r_state;
    state_t     w_state_nx;
    logic [7:0] r_grant;
    logic [7:0] w_grant_nx;
    logic [2:0] r_sel;
    logic [2:0] w_sel_nx;
    logic [2:0] r_ptr;
    logic [2:0] w_ptr_nx;
    logic [2:0] w_idx;
    logic [2:0] w_winner;
    logic       w_found;
    logic       w_xfer;
    logic       w_timeout;

    assign grant     = r_grant;
    assign sel       = r_sel;
    assign out_data  = in_data[r_sel*DW +: DW];
    assign out_valid = (r_state == BUSY) && req[r_sel];
    assign w_xfer    = out_valid && out_ready;
    assign ack       = w_xfer ? r_grant : 8'h00;

    // Search starts one past the last winner so it ends up lowest priority.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_ptr;
        w_idx    = '0;
        for (int k = 1; k < 9; k++) begin
            w_idx = r_ptr + 3'(k);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

`ifdef MUX8_ARB_TIMEOUT_EN
    logic [7:0] r_hold;
    logic       r_preempt;

    assign w_timeout = (r_hold == 8'(MAX_HOLD - 1));
    assign preempt   = r_preempt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold    <= '0;
            r_preempt <= 1'b0;
        end else begin
            r_preempt <= (r_state == BUSY) && w_timeout
                         && !(w_xfer && last[r_sel]);
            if (r_state == IDLE) begin
                if (w_found) r_hold <= '0;
            end else begin
                r_hold <= r_hold + 8'd1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign preempt   = 1'b0;
`endif

    always_comb begin
        w_state_nx = r_state;
        w_grant_nx = r_grant;
        w_sel_nx   = r_sel;
        w_ptr_nx   = r_ptr;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nx = BUSY;
                    w_grant_nx = 8'b1 << w_winner;
                    w_sel_nx   = w_winner;
                    w_ptr_nx   = w_winner;
                end
            end
            BUSY: begin
                if ((w_xfer && last[r_sel]) || w_timeout) begin
                    w_state_nx = IDLE;
                    w_grant_nx = 8'h00;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= 8'h00;
            r_sel   <= 3'd0;
            r_ptr   <= 3'd7;
        end else begin
            r_state <= w_state_nx;
            r_grant <= w_grant_nx;
            r_sel   <= w_sel_nx;
            r_ptr   <= w_ptr_nx;
        end
    end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Scoreboard bench for mux8_rr_arbiter: directed bursts, stalls, timeout, reset.
// Expected beats are queued by the stimulus and checked by a negedge monitor.
module tb_mux8_rr_arbiter;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    req;
    logic [7:0]    last;
    logic [8*DW-1:0] in_data;
    logic [7:0]    ack;
    logic [7:0]    grant;
    logic [2:0]    sel;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          preempt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          idx;
        logic [15:0] data;
    } beat_t;

    beat_t q[$];

    mux8_rr_arbiter #(.DW(DW), .MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst), .req(req), .last(last),
        .in_data(in_data), .ack(ack), .grant(grant), .sel(sel),
        .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .preempt(preempt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] dat(input int i);
        return 16'(16'hD000 + i * 16'h0111);
    endfunction

    task automatic load_table();
        for (int i = 0; i < 8; i++) in_data[i*DW +: DW] = dat(i);
    endtask

    task automatic push(input int idx, input logic [15:0] d);
        beat_t b;
        b.idx  = idx;
        b.data = d;
        q.push_back(b);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Monitor: every transfer must match the head of the scoreboard.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", {24'h0, ack}, 32'h0);
                end else begin
                    b = q.pop_front();
                    chk("beat_sel", {29'h0, sel}, b.idx);
                    chk("beat_data", {16'h0, out_data}, {16'h0, b.data});
                    chk("beat_ack", {24'h0, ack}, 32'h1 << b.idx);
                end
            end else begin
                chk("idle_ack", {24'h0, ack}, 32'h0);
            end
        end
    end

    initial begin
        req       = 8'h00;
        last      = 8'h00;
        out_ready = 1'b0;
        load_table();
        do_reset();

        chk("rst_grant", {24'h0, grant}, 32'h0);
        chk("rst_sel", {29'h0, sel}, 32'h0);
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_preempt", {31'h0, preempt}, 32'h0);

        // Single-beat burst from requester 0
        in_data[15:0] = 16'hA5A5;
        req       = 8'h01;
        last      = 8'h01;
        out_ready = 1'b1;
        push(0, 16'hA5A5);
        tick();
        chk("t1_grant", {24'h0, grant}, 32'h01);
        chk("t1_sel", {29'h0, sel}, 32'h0);
        tick();
        chk("t1_idle", {24'h0, grant}, 32'h0);
        req = 8'h00;

        // Full rotation with all requesters active
        load_table();
        do_reset();
        req  = 8'hFF;
        last = 8'hFF;
        for (int k = 0; k < 9; k++) push(k % 8, dat(k % 8));
        for (int k = 0; k < 9; k++) begin
            tick();
            chk("rr_grant", {24'h0, grant}, 32'h1 << (k % 8));
            tick();
            chk("rr_bubble", {24'h0, grant}, 32'h0);
        end
        req = 8'h00;
        tick();

        // 4-beat burst from requester 3 while requester 5 waits
        req  = 8'h28;
        last = 8'h20;
        in_data[3*DW +: DW] = 16'h3001;
        push(3, 16'h3001);
        push(3, 16'h3002);
        push(3, 16'h3003);
        push(3, 16'h3004);
        tick();
        chk("b4_grant", {24'h0, grant}, 32'h08);
        for (int b = 2; b <= 4; b++) begin
            tick();
            in_data[3*DW +: DW] = 16'(16'h3000 + b);
            last[3] = (b == 4);
        end
        tick();
        chk("b4_release", {24'h0, grant}, 32'h0);
        req  = 8'h20;
        last = 8'h00;
        in_data[5*DW +: DW] = 16'h5001;
        push(5, 16'h5001);
        tick();
        chk("b4_next_grant", {24'h0, grant}, 32'h20);

        // Backpressure stall during requester 5's burst
        tick();
        out_ready = 1'b0;
        in_data[5*DW +: DW] = 16'h5002;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("stall_valid", {31'h0, out_valid}, 32'h1);
            chk("stall_ack", {24'h0, ack}, 32'h0);
            chk("stall_grant", {24'h0, grant}, 32'h20);
            chk("stall_data", {16'h0, out_data}, 32'h5002);
            tick();
        end
        out_ready = 1'b1;
        last      = 8'h20;
        push(5, 16'h5002);
        tick();
        chk("stall_release", {24'h0, grant}, 32'h0);
        req  = 8'h00;
        last = 8'h00;

        // Owner never ends its burst
        do_reset();
        load_table();
        req       = 8'h44;
        last      = 8'h00;
        out_ready = 1'b0;
`ifdef MUX8_ARB_TIMEOUT_EN
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("to_grant", {24'h0, grant}, 32'h04);
            chk("to_no_preempt", {31'h0, preempt}, 32'h0);
        end
        tick();
        chk("to_idle", {24'h0, grant}, 32'h0);
        chk("to_preempt", {31'h0, preempt}, 32'h1);
        tick();
        chk("to_next_grant", {24'h0, grant}, 32'h40);
        chk("to_preempt_off", {31'h0, preempt}, 32'h0);
`else
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("hold_grant", {24'h0, grant}, 32'h04);
            chk("hold_preempt", {31'h0, preempt}, 32'h0);
        end
`endif
        req = 8'h00;

        // Reset during the second beat of a burst
        do_reset();
        req       = 8'h02;
        last      = 8'h00;
        out_ready = 1'b1;
        push(1, dat(1));
        tick();
        chk("mr_grant", {24'h0, grant}, 32'h02);
        tick();
        rst       = 1'b1;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
        chk("mr_grant0", {24'h0, grant}, 32'h0);
        chk("mr_sel0", {29'h0, sel}, 32'h0);
        chk("mr_valid0", {31'h0, out_valid}, 32'h0);
        req       = 8'h81;
        last      = 8'h81;
        out_ready = 1'b1;
        push(0, dat(0));
        tick();
        chk("mr_first", {24'h0, grant}, 32'h01);
        tick();
        req = 8'h00;
        tick();
        tick();
        chk("sb_drained", q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
